// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side bit-timing controller for a UART receiver.
// Synchronizes the raw line, qualifies the start bit, majority-votes every
// bit around its centre on the oversampling tick, strobes data bits into the
// deserializer LSB first, then checks parity and stop and reports the result.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic OVS_TICK,
    input  logic RX_IN,
    input  logic PAR_EN,
    input  logic PAR_TYP,
    output logic SHIFT_EN,
    output logic SAMPLE_BIT,
    output logic RX_DONE,
    output logic DATA_VALID,
    output logic PAR_ERR,
    output logic STOP_ERR,
    output logic BUSY
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int H  = OVERSAMPLE / 2;

    // Tick positions within one bit period (pre-increment tick_cnt values).
    localparam logic [TW-1:0] CNT_PRE  = TW'(H - 1);
    localparam logic [TW-1:0] CNT_MID  = TW'(H);
    localparam logic [TW-1:0] CNT_DEC  = TW'(H + 1);
    localparam logic [TW-1:0] CNT_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [BW-1:0]   bit_cnt_q;
    logic            samp_a_q;
    logic            samp_b_q;
    logic            acc_q;
    logic            par_en_q;
    logic            par_typ_q;
    logic            shift_en_q;
    logic            sample_bit_q;
    logic            rx_done_q;
    logic            data_valid_q;
    logic            par_err_q;
    logic            stop_err_q;
    logic            busy_q;

    logic            voted;
    logic            at_pre;
    logic            at_mid;
    logic            at_dec;
    logic            at_end;
    logic [TW-1:0]   tick_cnt_d;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Tick-position decode and 2-of-3 vote (third sample is the live rx_s).
    always_comb begin
        at_pre     = (tick_cnt_q == CNT_PRE);
        at_mid     = (tick_cnt_q == CNT_MID);
        at_dec     = (tick_cnt_q == CNT_DEC);
        at_end     = (tick_cnt_q == CNT_END);
        voted      = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
        tick_cnt_d = at_end ? '0 : tick_cnt_q + 1'b1;
    end

    // Frame FSM with registered strobes and status; everything moves only on a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_a_q     <= 1'b0;
            samp_b_q     <= 1'b0;
            acc_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            shift_en_q   <= 1'b0;
            sample_bit_q <= 1'b0;
            rx_done_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            shift_en_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            data_valid_q <= 1'b0;
            if (OVS_TICK) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s_q) begin
                            // Start edge: freeze this frame's configuration, clear status.
                            state_q    <= START;
                            busy_q     <= 1'b1;
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            par_en_q   <= PAR_EN;
                            par_typ_q  <= PAR_TYP;
                            par_err_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                            acc_q      <= 1'b0;
                        end
                    end
                    default: begin
                        tick_cnt_q <= tick_cnt_d;
                        if (at_pre) samp_a_q <= rx_s_q;
                        if (at_mid) samp_b_q <= rx_s_q;
                        case (state_q)
                            START: begin
                                if (at_dec && voted) begin
                                    // Line was back high at mid-start: a glitch, not a frame.
                                    state_q    <= IDLE;
                                    busy_q     <= 1'b0;
                                    tick_cnt_q <= '0;
                                end else if (at_end) begin
                                    state_q <= DATA;
                                end
                            end
                            DATA: begin
                                if (at_dec) begin
                                    shift_en_q   <= 1'b1;
                                    sample_bit_q <= voted;
                                    acc_q        <= acc_q ^ voted;
                                    bit_cnt_q    <= bit_cnt_q + 1'b1;
                                end
                                if (at_end && bit_cnt_q == BIT_LAST) begin
                                    state_q <= par_en_q ? PARITY : STOP;
                                end
                            end
                            PARITY: begin
                                if (at_dec) par_err_q <= voted ^ acc_q ^ par_typ_q;
                                if (at_end) state_q <= STOP;
                            end
                            STOP: begin
                                if (at_dec) begin
                                    // Leave early so a start bit right after stop is not missed.
                                    stop_err_q   <= ~voted;
                                    rx_done_q    <= 1'b1;
                                    data_valid_q <= voted & ~par_err_q;
                                    state_q      <= IDLE;
                                    busy_q       <= 1'b0;
                                    tick_cnt_q   <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    assign SHIFT_EN   = shift_en_q;
    assign SAMPLE_BIT = sample_bit_q;
    assign RX_DONE    = rx_done_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STOP_ERR   = stop_err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl (DATA_WIDTH = 8, OVERSAMPLE = 16).
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic OVS_TICK = 1'b1;
    logic RX_IN = 1'b1;
    logic PAR_EN = 1'b0;
    logic PAR_TYP = 1'b0;
    logic SHIFT_EN, SAMPLE_BIT, RX_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BUSY;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic bits_q[$];
    int   times_q[$];
    logic dv_q[$];
    logic pe_q[$];
    logic se_q[$];

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .OVS_TICK(OVS_TICK), .RX_IN(RX_IN),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .SHIFT_EN(SHIFT_EN),
        .SAMPLE_BIT(SAMPLE_BIT), .RX_DONE(RX_DONE), .DATA_VALID(DATA_VALID),
        .PAR_ERR(PAR_ERR), .STOP_ERR(STOP_ERR), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    // Record strobes and frame results 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (SHIFT_EN) begin
            bits_q.push_back(SAMPLE_BIT);
            times_q.push_back(cyc);
            $display("shift: cyc=%0d bit=%0b", cyc, SAMPLE_BIT);
        end
        if (RX_DONE) begin
            dv_q.push_back(DATA_VALID);
            pe_q.push_back(PAR_ERR);
            se_q.push_back(STOP_ERR);
            $display("done:  cyc=%0d valid=%0b par_err=%0b stop_err=%0b", cyc, DATA_VALID, PAR_ERR, STOP_ERR);
        end
    end

    // Drive one frame, 16 clocks per bit; optional single-clock noise at the centre of a data bit
    // and optional early exit once the total shift count reaches abort_at.
    task automatic send_frame(input logic [7:0] data, input logic with_par, input logic par_bit,
                              input logic stop_bit, input int noise_bit, input int abort_at);
        logic fb[11];
        int nb;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = data[i];
        nb = 9;
        if (with_par) begin
            fb[nb] = par_bit;
            nb++;
        end
        fb[nb] = stop_bit;
        nb++;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                RX_IN = fb[b] ^ ((noise_bit >= 0 && b == noise_bit + 1 && j == 9) ? 1'b1 : 1'b0);
                if (abort_at > 0 && bits_q.size() >= abort_at) return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({SHIFT_EN, SAMPLE_BIT, RX_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BUSY} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 0000000", {SHIFT_EN, SAMPLE_BIT, RX_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BUSY});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({SHIFT_EN, RX_DONE, BUSY} !== 3'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b expected 000", {SHIFT_EN, RX_DONE, BUSY});
        end
    endtask

    task automatic test_clean_frame();
        int base = bits_q.size();
        int dbase = dv_q.size();
        logic [7:0] rebuilt = 8'h00;
        logic [7:0] exp_byte = 8'hA5;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 0);
            begin
                // Configuration flips mid-frame must not affect this frame.
                repeat (40) @(negedge clk);
                PAR_TYP = 1'b1;
                PAR_EN = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        n_cmp++;
        if (bits_q.size() - base !== 8) begin
            n_err++;
            $display("FAIL clean_shift_count: got %0d expected 8", bits_q.size() - base);
        end
        for (int i = 0; i < 8 && base + i < bits_q.size(); i++) begin
            rebuilt = {bits_q[base+i], rebuilt[7:1]};
            n_cmp++;
            if (bits_q[base+i] !== exp_byte[i]) begin
                n_err++;
                $display("FAIL clean_bit%0d: got %b expected %b", i, bits_q[base+i], exp_byte[i]);
            end
            if (i > 0) begin
                n_cmp++;
                if (times_q[base+i] - times_q[base+i-1] !== 16) begin
                    n_err++;
                    $display("FAIL clean_spacing%0d: got %0d expected 16", i, times_q[base+i] - times_q[base+i-1]);
                end
            end
        end
        n_cmp++;
        if (rebuilt !== 8'hA5) begin
            n_err++;
            $display("FAIL clean_rebuilt: got %h expected a5", rebuilt);
        end
        n_cmp++;
        if (dv_q.size() - dbase !== 1) begin
            n_err++;
            $display("FAIL clean_done_count: got %0d expected 1", dv_q.size() - dbase);
        end else begin
            n_cmp++;
            if ({dv_q[dbase], pe_q[dbase], se_q[dbase]} !== 3'b100) begin
                n_err++;
                $display("FAIL clean_status: got valid/pe/se=%b expected 100", {dv_q[dbase], pe_q[dbase], se_q[dbase]});
            end
        end
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL clean_busy_after: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_glitch();
        int base = bits_q.size();
        int dbase = dv_q.size();
        repeat (4) begin
            @(negedge clk);
            RX_IN = 1'b0;
        end
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_busy_start: got %b expected 1", BUSY);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy_end: got %b expected 0", BUSY);
        end
        n_cmp++;
        if ((bits_q.size() - base) !== 0 || (dv_q.size() - dbase) !== 0) begin
            n_err++;
            $display("FAIL glitch_no_activity: got shifts=%0d dones=%0d expected 0/0", bits_q.size() - base, dv_q.size() - dbase);
        end
    endtask

    task automatic test_parity_err();
        int dbase = dv_q.size();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, 0);
        repeat (30) @(negedge clk);
        n_cmp++;
        if (dv_q.size() - dbase !== 1) begin
            n_err++;
            $display("FAIL parity_done_count: got %0d expected 1", dv_q.size() - dbase);
        end else begin
            n_cmp++;
            if ({dv_q[dbase], pe_q[dbase], se_q[dbase]} !== 3'b010) begin
                n_err++;
                $display("FAIL parity_status: got valid/pe/se=%b expected 010", {dv_q[dbase], pe_q[dbase], se_q[dbase]});
            end
        end
        n_cmp++;
        if (PAR_ERR !== 1'b1) begin
            n_err++;
            $display("FAIL parity_hold: got %b expected 1", PAR_ERR);
        end
    endtask

    task automatic test_stop_err();
        int base = bits_q.size();
        int dbase = dv_q.size();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, 0);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (dv_q.size() - dbase !== 1) begin
            n_err++;
            $display("FAIL stop_done_count: got %0d expected 1", dv_q.size() - dbase);
        end else begin
            n_cmp++;
            if ({dv_q[dbase], pe_q[dbase], se_q[dbase]} !== 3'b001) begin
                n_err++;
                $display("FAIL stop_status: got valid/pe/se=%b expected 001", {dv_q[dbase], pe_q[dbase], se_q[dbase]});
            end
        end
        n_cmp++;
        if (bits_q.size() - base !== 8 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL stop_aftermath: got shifts=%0d busy=%b expected 8/0", bits_q.size() - base, BUSY);
        end
    endtask

    task automatic test_noise();
        int base = bits_q.size();
        int dbase = dv_q.size();
        logic [7:0] exp_byte = 8'hA5;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 3, 0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bits_q.size() - base !== 8) begin
            n_err++;
            $display("FAIL noise_shift_count: got %0d expected 8", bits_q.size() - base);
        end
        for (int i = 0; i < 8 && base + i < bits_q.size(); i++) begin
            n_cmp++;
            if (bits_q[base+i] !== exp_byte[i]) begin
                n_err++;
                $display("FAIL noise_bit%0d: got %b expected %b", i, bits_q[base+i], exp_byte[i]);
            end
        end
        n_cmp++;
        if (dv_q.size() - dbase !== 1 || dv_q[dv_q.size()-1] !== 1'b1) begin
            n_err++;
            $display("FAIL noise_valid: got dones=%0d expected 1 valid frame", dv_q.size() - dbase);
        end
    endtask

    task automatic test_back_to_back();
        int base = bits_q.size();
        int dbase = dv_q.size();
        logic [15:0] exp_bits = 16'hC33C;
        PAR_EN = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, -1, 0);
        repeat (30) @(negedge clk);
        PAR_EN = 1'b1;
        n_cmp++;
        if (bits_q.size() - base !== 16) begin
            n_err++;
            $display("FAIL b2b_shift_count: got %0d expected 16", bits_q.size() - base);
        end
        for (int i = 0; i < 16 && base + i < bits_q.size(); i++) begin
            n_cmp++;
            if (bits_q[base+i] !== exp_bits[i]) begin
                n_err++;
                $display("FAIL b2b_bit%0d: got %b expected %b", i, bits_q[base+i], exp_bits[i]);
            end
        end
        n_cmp++;
        if (dv_q.size() - dbase !== 2) begin
            n_err++;
            $display("FAIL b2b_done_count: got %0d expected 2", dv_q.size() - dbase);
        end else begin
            n_cmp++;
            if ({dv_q[dbase], dv_q[dbase+1]} !== 2'b11) begin
                n_err++;
                $display("FAIL b2b_valid: got %b expected 11", {dv_q[dbase], dv_q[dbase+1]});
            end
        end
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy_after: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_tick_gating();
        OVS_TICK = 1'b0;
        @(negedge clk);
        RX_IN = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL tick_gating_busy: got %b expected 0", BUSY);
        end
        RX_IN = 1'b1;
        repeat (4) @(negedge clk);
        OVS_TICK = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL tick_gating_resume: got %b expected 0", BUSY);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = bits_q.size();
        int base2;
        logic [7:0] exp_byte = 8'h55;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, base + 4);
        n_cmp++;
        if (BUSY !== 1'b1 || bits_q.size() - base !== 4) begin
            n_err++;
            $display("FAIL midreset_precondition: got busy=%b shifts=%0d expected 1/4", BUSY, bits_q.size() - base);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({SHIFT_EN, SAMPLE_BIT, RX_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BUSY} !== 7'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b expected 0000000", {SHIFT_EN, SAMPLE_BIT, RX_DONE, DATA_VALID, PAR_ERR, STOP_ERR, BUSY});
        end
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (bits_q.size() - base !== 4) begin
            n_err++;
            $display("FAIL midreset_no_shift: got %0d expected 4", bits_q.size() - base);
        end
        base2 = bits_q.size();
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, -1, 0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (bits_q.size() - base2 !== 8) begin
            n_err++;
            $display("FAIL midreset_frame_count: got %0d expected 8", bits_q.size() - base2);
        end
        for (int i = 0; i < 8 && base2 + i < bits_q.size(); i++) begin
            n_cmp++;
            if (bits_q[base2+i] !== exp_byte[i]) begin
                n_err++;
                $display("FAIL midreset_bit%0d: got %b expected %b", i, bits_q[base2+i], exp_byte[i]);
            end
        end
        n_cmp++;
        if (dv_q.size() == 0 || dv_q[dv_q.size()-1] !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_valid: got %0d dones, last not valid; expected valid frame", dv_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_parity_err();
        test_stop_err();
        test_noise();
        test_back_to_back();
        test_tick_gating();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
